// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: sequencer state encoding,
// default geometry and a small address range helper.
package ram_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 3;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // True when addr names an existing word of a depth-entry array.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Power-up clearing sequencer: walks addresses 0..DEPTH-1 writing zero,
// one word per cycle, holding busy high until the last word is cleared.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int DEPTH   = 2 ** A_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               busy,
    output logic               clr_en,
    output logic [A_WIDTH-1:0] clr_addr
);

    localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;

    // State and clear pointer; reset always restarts clearing from word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance the pointer each INIT cycle, leave after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            INIT: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                busy = 1'b0;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_dp.sv
// Simple dual-port RAM (one write port, one registered read port) with
// self-clearing after reset and out-of-range address detection.
// Optional macro RAM_BYPASS_EN: same-cycle same-address read returns the
// incoming write data (write-first); otherwise the old contents (read-first).
module ram_dp
    import ram_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int DEPTH   = 2 ** A_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_err,
    output logic               busy
);

    // Index width sized to the real array so short arrays index cleanly.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic               clr_en;
    logic [A_WIDTH-1:0] clr_addr;
    logic               wr_hit, rd_hit, wr_ok, rd_ok;
    logic               mem_we;
    logic [IW-1:0]      mem_waddr;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] rd_word;

    ram_init_ctrl #(
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) u_init (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign wr_hit = addr_in_range(32'(wr_addr), 32'(DEPTH));
    assign rd_hit = addr_in_range(32'(rd_addr), 32'(DEPTH));

    // User requests only count once clearing is done and reset is released.
    assign wr_ok = rst_n && !busy && wr_en && wr_hit;
    assign rd_ok = !busy && rd_en;

    // Single memory write port shared by the clearing sequencer and users.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (rst_n && clr_en) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr[IW-1:0];
        end else if (wr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr[IW-1:0];
            mem_wdata = wr_data;
        end
    end

    // Storage array; contents are defined only by the clearing pass, never by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read word selection; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (rd_hit) begin
            rd_word = mem[rd_addr[IW-1:0]];
`ifdef RAM_BYPASS_EN
            if (wr_ok && (wr_addr == rd_addr)) begin
                rd_word = wr_data;
            end
`endif
        end
    end

    // Registered read port; data holds when idle, reset drops any pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else if (rd_ok) begin
            rd_data  <= rd_word;
            rd_valid <= 1'b1;
            rd_err   <= !rd_hit;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 D_WIDTH, 8, data word width in bits.
REQ-002 A_WIDTH, 3, address width in bits.
REQ-003 DEPTH, 2**A_WIDTH, number of words; legal range 2..2**A_WIDTH.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 wr_en  in  1  write request for the current cycle.
REQ-007 wr_addr  in  A_WIDTH  write address.
REQ-008 wr_data  in  D_WIDTH  write data.
REQ-009 rd_en  in  1  read request for the current cycle.
REQ-010 rd_addr  in  A_WIDTH  read address.
REQ-011 rd_data  out  D_WIDTH  registered read data.
REQ-012 rd_valid  out  1  rd_data holds the result of the read accepted on the previous cycle.
REQ-013 rd_err  out  1  the read accepted on the previous cycle used rd_addr >= DEPTH.
REQ-014 busy  out  1  initialisation in progress; all requests are ignored.

Function
REQ-015 The block SHALL have two states: INIT and READY.
REQ-016 In INIT, the block SHALL write zero to one word per cycle, addresses 0 to DEPTH-1 in order, then move to READY (DEPTH cycles in INIT); busy = 1 throughout INIT.
REQ-017 In READY, busy SHALL be 0, and the block SHALL accept wr_en and rd_en independently in the same cycle.
REQ-018 A write with wr_addr < DEPTH SHALL update memory at the clock edge; a write with wr_addr >= DEPTH SHALL be discarded without any side effect.
REQ-019 The block SHALL have a read latency of 1 cycle: for a read accepted at edge N, rd_data, rd_valid = 1 and rd_err SHALL be presented after edge N+1.
REQ-020 A read with rd_addr >= DEPTH SHALL return rd_data = 0 with rd_err = 1.
REQ-021 When no read is accepted, rd_valid and rd_err SHALL be 0 and rd_data SHALL hold its last value.
REQ-022 For a read and write to the same address in the same cycle, the read data SHALL follow REQ-030/REQ-031.
REQ-023 Requests made while busy = 1 SHALL have no effect: no memory update and rd_valid = 0.

Reset
REQ-024 While rst_n = 0 at a clock edge, the block SHALL set rd_data = 0, rd_valid = 0, rd_err = 0, busy = 1, init counter = 0 and state = INIT.
REQ-025 On the first edge with rst_n = 1, clearing of word 0 SHALL begin, and busy SHALL fall after DEPTH such edges.
REQ-026 Reset asserted during INIT SHALL restart clearing from address 0.
REQ-027 Reset asserted during READY SHALL discard any pending read result.
REQ-028 Memory contents SHALL be undefined only while rst_n is low or the block is in INIT.
REQ-029 No asynchronous reset path SHALL exist.

Configuration
REQ-030 With RAM_BYPASS_EN defined, a same-cycle same-address read and write (address < DEPTH) SHALL return the new wr_data (write-first).
REQ-031 Without RAM_BYPASS_EN, the same case SHALL return the old contents (read-first), and the bypass mux SHALL be absent.

Structure
REQ-032 The shared package ram_pkg SHALL hold the state encoding (INIT, READY) and the default width constants.
REQ-033 The INIT sequencer (counter, state, busy) SHALL be a sub-module, ram_init_ctrl; the storage array and read port SHALL stay in ram_dp.

Verification
REQ-034 Reset release, D_WIDTH=8, A_WIDTH=3, DEPTH=8 -> busy = 1 for exactly 8 cycles; then reads of addresses 0..7 return 0x00 with rd_valid = 1.
REQ-035 Write 0xA5 to address 3, then read address 3 on the next cycle -> rd_data = 0xA5 one cycle later, rd_valid = 1, rd_err = 0.
REQ-036 Address 2 holds 0x11; write 0x22 and read address 2 in the same cycle -> rd_data = 0x22 with RAM_BYPASS_EN, 0x11 without.
REQ-037 DEPTH=6: write 0xFF to address 7, then read address 7 -> rd_data = 0x00, rd_err = 1; a read of address 5 is unaffected.
REQ-038 Assert rst_n low at INIT cycle 4 for 1 cycle -> busy stays 1 for 8 further cycles; a write of 0x33 to address 0 during busy is lost (a later read returns 0x00).
REQ-039 Back-to-back reads of addresses 0,1,2 with no read on the 4th cycle -> rd_valid sequence 1,1,1,0 and rd_data holds its last value on the 4th cycle.
